// File: rtl/frame_rx_pkg.sv
// Shared types and frame constants for the serial frame receiver with
// a commit/rollback byte FIFO.
package frame_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} rx_state_t;

  localparam int FS_BITS     = 4;
  localparam int CRC_BITS    = 8;
  localparam int MIN_BAUD    = 3;
  localparam int NOISE_LIMIT = 2;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, zero initial value.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? POLY : 8'h00);
  end
endmodule

// File: rtl/frame_rx_fifo.sv
// Oversampled serial frame receiver; bytes are staged into a FIFO and only
// become visible once the frame's CRC and stop bit check out.
module frame_rx_fifo
  import frame_rx_pkg::*;
#(
  parameter int         BW    = 8,
  parameter int         DEPTH = 32,
  parameter logic [7:0] POLY  = 8'h07
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic [BW-1:0]            baudrate,
  input  logic                     rd,
  output logic [7:0]               dataout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dr,
  output logic                     nf,
  output logic                     fe,
  output logic                     ce,
  output logic                     over
);
  localparam int AW = $clog2(DEPTH);

  rx_state_t     state, state_nxt;
  logic [BW-1:0] baud_lat, smp_cnt, ones, zeros;
  logic [BW-1:0] ones_n, zeros_n, minority;
  logic          bit_done, bit_val, bit_noise;
  logic [2:0]    bit_cnt;
  logic [4:0]    byte_cnt, fs_len;
  logic [7:0]    shift, field, crc;
  logic [AW:0]   wr_ptr, wr_tmp, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          crc_clr, crc_en, field_done, staged_full, byte_wr;

  // Voting includes the current sample, so the bit resolves on sample B itself.
  always_comb begin
    ones_n    = ones + BW'(rx);
    zeros_n   = zeros + BW'(!rx);
    bit_done  = (state != IDLE) && ((smp_cnt + BW'(1)) == baud_lat);
    bit_val   = ones_n > zeros_n;
    minority  = bit_val ? zeros_n : ones_n;
    bit_noise = (minority > BW'(NOISE_LIMIT)) || (ones_n == zeros_n);
    field     = {shift[6:0], bit_val};
  end

  always_comb begin
    state_nxt  = state;
    field_done = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    case (state)
      IDLE:  if (rx) state_nxt = START;
      START: if (bit_done) begin
        field_done = 1'b1;
        crc_clr    = bit_val;
        state_nxt  = bit_val ? SIZE : IDLE;
      end
      SIZE:  if (bit_done) begin
        crc_en = 1'b1;
        if (bit_cnt == 3'(FS_BITS - 1)) begin
          field_done = 1'b1;
          state_nxt  = DATA;
        end
      end
      DATA:  if (bit_done) begin
        crc_en = 1'b1;
        if (bit_cnt == 3'd7) begin
          field_done = 1'b1;
          if (byte_cnt == fs_len - 5'd1) state_nxt = CRC;
        end
      end
      CRC:   if (bit_done && bit_cnt == 3'(CRC_BITS - 1)) begin
        field_done = 1'b1;
        state_nxt  = STOP;
      end
      STOP:  if (bit_done) begin
        field_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign staged_full = (wr_tmp - rd_ptr) == (AW+1)'(DEPTH);
  assign byte_wr     = (state == DATA) && field_done && !over && !staged_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_lat <= BW'(MIN_BAUD);
      smp_cnt  <= '0;
      ones     <= '0;
      zeros    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      fs_len   <= 5'd16;
      shift    <= '0;
      wr_ptr   <= '0;
      wr_tmp   <= '0;
      rd_ptr   <= '0;
      dr       <= 1'b0;
      nf       <= 1'b0;
      fe       <= 1'b0;
      ce       <= 1'b0;
      over     <= 1'b0;
    end else begin
      dr <= 1'b0;
      if (state == IDLE) begin
        if (rx) begin
          // The detecting sample is the first sample of the start bit.
          baud_lat <= (baudrate < BW'(MIN_BAUD)) ? BW'(MIN_BAUD) : baudrate;
          smp_cnt  <= BW'(1);
          ones     <= BW'(1);
          zeros    <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          nf       <= 1'b0;
          fe       <= 1'b0;
          ce       <= 1'b0;
          over     <= 1'b0;
        end
      end else if (bit_done) begin
        smp_cnt <= '0;
        ones    <= '0;
        zeros   <= '0;
        shift   <= field;
        bit_cnt <= field_done ? 3'd0 : bit_cnt + 3'd1;
        if (bit_noise) nf <= 1'b1;
      end else begin
        smp_cnt <= smp_cnt + BW'(1);
        ones    <= ones_n;
        zeros   <= zeros_n;
      end

      case (state)
        START: if (bit_done && !bit_val) nf <= 1'b1;
        SIZE:  if (field_done) fs_len <= (field[3:0] == 4'd0) ? 5'd16 : {1'b0, field[3:0]};
        DATA:  if (field_done) begin
          byte_cnt <= byte_cnt + 5'd1;
          if (byte_wr)    wr_tmp <= wr_tmp + (AW+1)'(1);
          else if (!over) over   <= 1'b1;
        end
        CRC:   if (field_done && field != crc) ce <= 1'b1;
        STOP:  if (field_done) begin
          if (bit_val) fe <= 1'b1;
          if (!bit_val && !ce && !over) begin
            wr_ptr <= wr_tmp;
            dr     <= 1'b1;
          end else begin
            wr_tmp <= wr_ptr;
          end
        end
        default: ;
      endcase

      if (rd && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (byte_wr) mem[wr_tmp[AW-1:0]] <= field;
  end

  crc8_serial #(.POLY(POLY)) u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (bit_val),
    .crc   (crc)
  );

  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign dataout = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
endmodule

// File: doc/frame_rx_fifo.md
# frame_rx_fifo

Parametrised successor to the single-byte serial frame receiver. Oversamples `rx` at `baudrate` clocks per bit and majority-votes each bit. Parses start / 4-bit frame-size / N data bytes / CRC-8 / stop, and stages bytes into an internal FIFO. A frame's bytes become visible to the host only after its CRC and stop bit check out; a bad frame is rolled back.

## Interface
- `BW`, 8 — width of `baudrate`.
- `DEPTH`, 32 — FIFO entries, power of two, at least 16.
- `POLY`, 8'h07 — CRC-8 polynomial; initial value 8'h00; MSB-first.
- `clk` in 1 — sole clock.
- `reset` in 1 — asynchronous, active-high.
- `rx` in 1 — serial line; idles 0.
- `baudrate` in BW — clocks per bit; values below 3 are treated as 3.
- `rd` in 1 — pop the head byte; ignored when `empty`.
- `dataout` out 8 — head byte, first-word-fall-through.
- `empty` out 1 — no committed bytes.
- `count` out $clog2(DEPTH)+1 — number of committed bytes.
- `dr` out 1 — one-cycle pulse on a good frame commit.
- `nf` out 1 — noise flag.
- `fe` out 1 — framing error.
- `ce` out 1 — CRC error.
- `over` out 1 — frame dropped because the FIFO filled.

## Operation
- **States:** IDLE, START, SIZE, DATA, CRC, STOP.
- **IDLE:**
  - `rx`=1 moves to START.
  - On that transition, `baudrate` is latched (clamped to ≥3) for the whole frame.
  - On that transition, `nf`, `fe`, `ce` and `over` are cleared.
- **Bit timing:**
  - A sample counter runs 1..B.
  - Ones and zeros are counted over the B samples.
  - At sample B the bit is resolved: 1 if ones>zeros, otherwise 0.
  - `nf` is set if the minority count is >2 (a tie counts as noise); it is sticky for the frame.
- **START:** a resolved 0 is a false start: return to IDLE with `nf` set and no other effect.
- **SIZE:**
  - 4 bits, MSB first, give FS.
  - FS=0 means 16 bytes.
  - The CRC engine is cleared on START→SIZE and is fed the FS bits and the data bits.
- **DATA:**
  - FS bytes, each MSB first.
  - Each byte is written at the staging pointer `wr_tmp`, which then increments.
  - If the FIFO would overflow (committed plus staged = DEPTH), set `over`, stop writing, and continue parsing the frame to the stop bit.
- **CRC:** 8 bits, MSB first, are compared with the engine output. On a mismatch, set `ce`.
- **STOP:**
  - A resolved 1 sets `fe`.
  - Frame end: if `fe`, `ce` and `over` are all 0, commit (`wr_ptr`←`wr_tmp`) and pulse `dr`.
  - Otherwise roll back (`wr_tmp`←`wr_ptr`).
  - In both cases return to IDLE.
- **Read side:**
  - `rd`&&!`empty` advances `rd_ptr`.
  - A pop in the same cycle as a commit is legal; `count` is updated by both.
- **Pointers:** $clog2(DEPTH)+1 bits, so wrap-around is distinguished by the MSB.
- **Reset mid-frame:** the FSM returns to IDLE, all pointers go to 0, and staged bytes are lost.

## Timing
- Reset values:
  - `dr`, `nf`, `fe`, `ce`, `over` = 0.
  - `empty` = 1.
  - `count` = 0.
  - `dataout` = 8'h00.
- A frame occupies (1+4+8·FS+8+1)·B clocks after the first `rx`=1 sample.
- `dr` pulses in the cycle after the stop bit's B-th sample.
- Committed bytes show on `dataout`/`count` in that same cycle.
- `dataout` is valid combinationally from `rd_ptr`.
- A pop takes effect on the next edge.
- Flags remain stable from their setting until the next START entry or reset.
- `baudrate` changes mid-frame have no effect until the next frame.

## Structure
- Package `frame_rx_pkg` holds:
  - The state enum `rx_state_t` (6 values).
  - Frame-field widths `FS_BITS`=4 and `CRC_BITS`=8.
  - `MIN_BAUD`=3.
  - `NOISE_LIMIT`=2.
- Sub-module `crc8_serial` (`clk`, `reset`, `clr`, `en`, `din`, `crc`[7:0]), parametrised by POLY.
- The oversampler/voter, FSM and FIFO are in the top module.

## Test plan
- B=8, FS=2, data A5,3C, correct CRC, stop 0 → one `dr` pulse, `count`=2, reads give A5 then 3C, no flags set.
- Same frame with the CRC LSB flipped → `ce`=1, no `dr`, `count` stays 0.
- Valid frame with stop bit 1 → `fe`=1, frame discarded. The next good frame then commits normally.
- B=8, 3 of the 8 samples of one data bit inverted → `nf`=1, the byte is still decoded correctly, the frame still commits.
- DEPTH=16 with 12 bytes held unread, then a frame with FS=5 → `over`=1, `count` stays 12. After 4 pops, a frame with FS=4 commits, `count`=12.
- Reset asserted mid-DATA → all outputs at reset values immediately. A subsequent frame is received correctly.
